mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//   Shares one external single-ported memory bus between instruction fetch (pc_reg/rom side)
//   and load/store (mem stage/ram side) of the openmips core. Serialises requests, handles
//   variable-latency slaves via req/ack, and raises per-requester stall requests to ctrl
//   so the pipeline holds until its access completes. Sits between openmips and the memory.
// PARAMETERS
//   ADDR_W        32   address width of all address ports
//   DATA_W        32   data width of all data ports
//   STARVE_LIMIT  4    consecutive data grants, with fetch waiting, before fetch is forced once
//   TIMEOUT_CYC   255  cycles in a BUSY state without bus_ack_i before abort with bus_err_o
// PORTS
//   clk            in   1       clock, all state on rising edge
//   rst            in   1       asynchronous reset, active-low
//   if_ce_i        in   1       fetch request (level, held stable while if_stallreq_o=1)
//   if_addr_i      in   ADDR_W  fetch address
//   if_data_o      out  DATA_W  fetched instruction, valid while if_done
//   if_stallreq_o  out  1       stall request to ctrl for fetch side
//   d_ce_i         in   1       data request (level, held stable while d_stallreq_o=1)
//   d_we_i         in   1       1=store, 0=load
//   d_sel_i        in   4       byte lanes
//   d_addr_i       in   ADDR_W  data address
//   d_wdata_i      in   DATA_W  store data
//   d_rdata_o      out  DATA_W  load data, valid while d_done
//   d_stallreq_o   out  1       stall request to ctrl for mem side
//   bus_req_o      out  1       registered bus request, held until ack or timeout
//   bus_we_o       out  1       registered write enable
//   bus_sel_o      out  4       registered byte lanes (4'b1111 for fetch)
//   bus_addr_o     out  ADDR_W  registered address
//   bus_wdata_o    out  DATA_W  registered write data
//   bus_rdata_i    in   DATA_W  read data, sampled in the bus_ack_i cycle
//   bus_ack_i      in   1       transfer complete; only meaningful while bus_req_o=1
//   bus_err_o      out  1       one-cycle pulse on timeout abort
// BEHAVIOUR
//   - Reset (rst=0, async): state IDLE; all outputs 0; starve/wait counters 0; done flags 0.
//   - FSM: IDLE -> BUSY_I | BUSY_D -> DONE -> IDLE.
//   - IDLE: if d_ce_i & (~if_ce_i | starve<STARVE_LIMIT) -> BUSY_D; else if if_ce_i -> BUSY_I.
//     Data wins ties (older instruction); starve increments per data grant while if_ce_i=1,
//     clears on any fetch grant; at STARVE_LIMIT fetch wins next tie.
//   - Entering BUSY_x: bus_* registered from the chosen requester's inputs, bus_req_o=1.
//   - BUSY_x: wait counter increments; on bus_ack_i: bus_req_o=0, latch bus_rdata_i into
//     x holding register (loads/fetch only; d_rdata_o unchanged on store), set x_done, -> DONE.
//   - Timeout: wait==TIMEOUT_CYC-1 without ack: bus_req_o=0, bus_err_o=1 one cycle,
//     holding register=0, x_done=1, -> DONE (no deadlock on absent slave).
//   - DONE: exactly one cycle; x_done=1 -> IDLE; no new grant issued in DONE.
//   - if_stallreq_o = if_ce_i & ~if_done ; d_stallreq_o = d_ce_i & ~d_done (combinational).
//   - Latency: request seen in IDLE cycle N -> bus_req_o at N+1 -> ack at earliest N+1 ->
//     done/stall released at N+2 (3-cycle minimum per access). Back-to-back: both pending
//     costs 6 cycles minimum (data then fetch).
//   - bus_ack_i outside BUSY ignored. Requester dropping ce mid-BUSY: access still completes
//     on the bus; result discarded, no stall effect.
//   - Reset mid-transfer: bus_req_o drops immediately; slave must tolerate abandonment.
// STRUCTURE
//   - define.v additions: `ArbIdle/`ArbBusyI/`ArbBusyD/`ArbDone (2-bit state codes),
//     `ArbStarveLimit, `ArbTimeoutCyc defaults.
//   - One sub-module: mem_arb_timer (wait counter, clear/enable, timeout strobe).
//   - openmips top: ctrl gains stallreq_from_if; stallreq_from_mem driven by d_stallreq_o.
// TESTING
//   - Fetch only, ack 2 cycles after req, rdata=32'h3C010001 -> if_stallreq 1 for 3 cycles,
//     if_data_o=32'h3C010001 in done cycle, bus_sel_o=4'hF.
//   - Simultaneous fetch+load, ack immediate -> data served first (bus_addr_o=d_addr_i),
//     then fetch; d_stallreq drops at N+2, if_stallreq at N+5.
//   - Store sel=4'b0011 wdata=32'hDEADBEEF -> bus_we_o=1, bus_sel_o=3, d_rdata_o unchanged.
//   - Data continuously requesting with fetch waiting, STARVE_LIMIT=4 -> 5th grant is fetch.
//   - No ack, TIMEOUT_CYC=8 -> bus_req_o low after 8 BUSY cycles, bus_err_o 1-cycle pulse,
//     if_data_o=0, stall released.
//   - rst=0 asserted mid-BUSY_D -> bus_req_o=0 same cycle, stalls 0 only if ce low, IDLE after.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: state encoding and default limits shared by the memory arbiter files
package mem_arbiter_pkg;
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2,
        ARB_DONE   = 2'd3
    } arb_state_e;
    localparam int ARB_STARVE_LIMIT = 4;
    localparam int ARB_TIMEOUT_CYC  = 255;
endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: bus wait counter with clear/enable and a timeout strobe
//   clk, rst_n : clock, async active-low reset
//   clr        : zero the counter (has priority over en)
//   en         : count one cycle of waiting
//   timeout    : high in the last allowed waiting cycle
module mem_arb_timer
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = ARB_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);
    localparam int W = $clog2(TIMEOUT_CYC + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else cnt <= clr ? '0 : en ? cnt + W'(1) : cnt;
    end
    assign timeout = en & (cnt == W'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory bus between instruction fetch and load/store
//   clk, rst_n           : clock, async active-low reset
//   if_ce_i/if_addr_i    : fetch request; if_data_o result, if_stallreq_o holds the pipeline
//   d_ce_i/d_we_i/d_sel_i/d_addr_i/d_wdata_i : data request; d_rdata_o result, d_stallreq_o stall
//   bus_req_o/we/sel/addr/wdata : registered bus request towards the slave
//   bus_rdata_i/bus_ack_i: slave response; bus_err_o pulses on a timeout abort
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT,
    parameter int TIMEOUT_CYC  = ARB_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_ce_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_stallreq_o,
    input  logic              d_ce_i,
    input  logic              d_we_i,
    input  logic [3:0]        d_sel_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_stallreq_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i,
    output logic              bus_err_o
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    arb_state_e state, state_nxt;
    logic [SW-1:0] starve;
    logic busy, fin, timeout, grant_d, grant_i, if_done, d_done;
    assign busy = (state == ARB_BUSY_I) || (state == ARB_BUSY_D);
    mem_arb_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (~busy),
        .en      (busy),
        .timeout (timeout)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ARB_IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = (state == ARB_IDLE) ? (grant_d ? ARB_BUSY_D : grant_i ? ARB_BUSY_I : ARB_IDLE) :
                    busy ? (fin ? ARB_DONE : state) : ARB_IDLE;
    end
    // Data wins ties unless fetch has been passed over STARVE_LIMIT times in a row.
    always_comb begin
        grant_d       = (state == ARB_IDLE) & d_ce_i & (~if_ce_i | (starve < SW'(STARVE_LIMIT)));
        grant_i       = (state == ARB_IDLE) & ~grant_d & if_ce_i;
        fin           = busy & (bus_ack_i | timeout);
        if_stallreq_o = if_ce_i & ~if_done;
        d_stallreq_o  = d_ce_i & ~d_done;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= 4'h0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_err_o   <= 1'b0;
            if_data_o   <= '0;
            d_rdata_o   <= '0;
            if_done     <= 1'b0;
            d_done      <= 1'b0;
            starve      <= '0;
        end else begin
            bus_err_o <= fin & ~bus_ack_i;
            if_done   <= fin & (state == ARB_BUSY_I);
            d_done    <= fin & (state == ARB_BUSY_D);
            if (grant_d) begin
                bus_req_o   <= 1'b1;
                bus_we_o    <= d_we_i;
                bus_sel_o   <= d_sel_i;
                bus_addr_o  <= d_addr_i;
                bus_wdata_o <= d_wdata_i;
                starve      <= starve + SW'(if_ce_i);
            end else if (grant_i) begin
                bus_req_o   <= 1'b1;
                bus_we_o    <= 1'b0;
                bus_sel_o   <= 4'hF;
                bus_addr_o  <= if_addr_i;
                bus_wdata_o <= '0;
                starve      <= '0;
            end
            // An ack in the timeout cycle still counts as a normal completion.
            if (fin) begin
                bus_req_o <= 1'b0;
                if (state == ARB_BUSY_I) if_data_o <= bus_ack_i ? bus_rdata_i : '0;
                else if (!bus_ack_i || !bus_we_o) d_rdata_o <= bus_ack_i ? bus_rdata_i : '0;
            end
        end
    end
endmodule
